// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// default parameter values.
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } meter_state_e;

  localparam int DEFAULT_CNT_WIDTH   = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_TIMEOUT     = 100_000_000;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous level into the clock_in domain and flags its
// rising edges. level_out is the synchronized level; rise_out is high for the
// one cycle in which the synchronized level goes from 0 to 1.
module sync_edge_detect
  import clock_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic level_out,
  output logic rise_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_dly_q, level_dly_d;

  // Shift the async input down the synchronizer chain and keep a delayed copy
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], async_in};
    level_dly_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-history registers
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign level_out = sync_q[SYNC_STAGES-1];
  assign rise_out  = level_out & ~level_dly_q;

endmodule

// File: rtl/clock_period_meter.sv
// One-shot period / high-time meter. After start, waits for a rising edge of
// the synchronized input, then counts clock_in cycles (and cycles spent high)
// up to the next rising edge. A timer bounds the whole measurement; on expiry
// the measurement is abandoned and the previous results are kept.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 sig_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 valid,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] period_count,
  output logic [CNT_WIDTH-1:0] high_count
);

  // Timer value on the last cycle a measurement may still complete
  localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  meter_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic                 s;
  logic                 rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in (sig_in),
    .level_out(s),
    .rise_out (rise)
  );

  // Next-state and counter logic; a completing rise takes priority over expiry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    timer_d   = timer_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_EDGE;
          timer_d = '0;
        end
      end
      WAIT_EDGE: begin
        timer_d = timer_q + CNT_ONE;
        if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end
      end
      MEASURE: begin
        timer_d = timer_q + CNT_ONE;
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hcnt_d = hcnt_q + CNT_WIDTH'(s);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, timer, result registers and one-cycle status pulses
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_q     <= '0;
      hcnt_q    <= '0;
      timer_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign valid        = valid_q;
  assign timeout      = timeout_q;
  assign period_count = period_q;
  assign high_count   = high_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: fixed vector table, reset sequences and
// randomized waveforms checked against an edge-list reference model.
module tb_clock_period_meter;

  localparam int CW   = 16;
  localparam int SS   = 2;
  localparam int TO   = 1000;
  localparam int HMAX = 65536;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          busy, valid, timeout;
  logic [CW-1:0] period_count, high_count;

  clock_period_meter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .clock_in    (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .start       (start),
    .busy        (busy),
    .valid       (valid),
    .timeout     (timeout),
    .period_count(period_count),
    .high_count  (high_count)
  );

  always #10 clk = ~clk;

  typedef struct {
    int off;
    int hi;
    int lo;
    bit extra;
    int kind;   // 1 = valid, 2 = timeout
    int per;
    int high;
    int lat;
  } vec_t;

  vec_t tbl[9];

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  bit hist[HMAX];        // sig_in value sampled at each rising edge
  bit overlap_seen;
  int last_per  = 0;
  int last_high = 0;
  bit rw_level  = 1'b0;
  int rw_left   = 0;
  int rw_max    = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for the next edge, advance one clock, sample #1 later
  task automatic step(input bit st, input bit sv, input bit rs);
    start  = st;
    sig_in = sv;
    reset  = rs;
    if (edge_n + 1 < HMAX) hist[edge_n+1] = sv;
    @(posedge clk);
    edge_n++;
    #1;
    if (valid === 1'b1 && timeout === 1'b1) overlap_seen = 1'b1;
  endtask

  // Periodic waveform whose first high sample is at edge S+off, or random dwell
  function automatic bit wave(input bit rnd, input int E, input int S, input int off,
                              input int hi, input int lo);
    int k;
    if (rnd) begin
      if (rw_left == 0) begin
        rw_level = ~rw_level;
        rw_left  = int'($urandom_range(rw_max, 1));
      end
      rw_left--;
      return rw_level;
    end
    k = E - S - off;
    return (k >= 0) && ((k % (hi + lo)) < hi);
  endfunction

  // Reference: rising edges of sig_in become visible SS edges later; the first
  // visible edge after start opens the window, the next closes it, all within
  // TO edges of start.
  function automatic void model(input int S, output int kind, output int lat,
                                output int per, output int high);
    int d0, d1;
    d0 = -1; d1 = -1;
    kind = 2; lat = TO; per = 0; high = 0;
    for (int d = S + 1; d <= S + TO; d++) begin
      int e;
      e = d - SS;
      if (!(hist[e] && !hist[e-1])) continue;
      if (d0 < 0) begin
        if (d < S + TO) d0 = d;
      end else begin
        d1 = d;
        break;
      end
    end
    if (d1 > 0) begin
      kind = 1;
      lat  = d1 - S;
      per  = d1 - d0;
      for (int e = d0 - SS; e < d1 - SS; e++) high += int'(hist[e]);
    end
  endfunction

  task automatic run_case(input string tag, input bit rnd, input int off, input int hi,
                          input int lo, input bit extra, input bit use_tbl, input int x_kind,
                          input int x_per, input int x_high, input int x_lat);
    int S, kind, lat, per_o, high_o;
    int xk, xl, xp, xh;
    bit busy_o, busy_gap, after_pulse;
    S = edge_n + 9;
    kind = 0; lat = 0; per_o = 0; high_o = 0; busy_o = 1'b1; busy_gap = 1'b0;
    overlap_seen = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, wave(rnd, edge_n + 1, S, off, hi, lo), 1'b0);
    check({tag, ":busy_idle"}, busy, 0);
    for (int i = 0; i < TO + 20 && kind == 0; i++) begin
      int E;
      bit st;
      E  = edge_n + 1;
      st = (E == S) || (extra && E > S + 1 && ((E - S) % 7 == 0));
      step(st, wave(rnd, E, S, off, hi, lo), 1'b0);
      if (edge_n == S) begin
        check({tag, ":busy_start"}, busy, 1);
      end else if (edge_n > S) begin
        if (valid === 1'b1 || timeout === 1'b1) begin
          kind   = (valid === 1'b1) ? 1 : 2;
          lat    = edge_n - S;
          per_o  = int'(period_count);
          high_o = int'(high_count);
          busy_o = busy;
        end else if (busy !== 1'b1) begin
          busy_gap = 1'b1;
        end
      end
    end
    step(1'b0, wave(rnd, edge_n + 1, S, off, hi, lo), 1'b0);
    after_pulse = (valid !== 1'b0) || (timeout !== 1'b0);
    if (use_tbl) begin
      xk = x_kind; xl = x_lat; xp = x_per; xh = x_high;
    end else begin
      model(S, xk, xl, xp, xh);
      if (xk == 2) begin
        xp = last_per;
        xh = last_high;
      end
    end
    check({tag, ":kind"}, kind, xk);
    check({tag, ":latency"}, lat, xl);
    check({tag, ":period_count"}, per_o, xp);
    check({tag, ":high_count"}, high_o, xh);
    check({tag, ":busy_at_pulse"}, busy_o, 0);
    check({tag, ":busy_gap"}, busy_gap, 0);
    check({tag, ":pulse_width"}, after_pulse, 0);
    check({tag, ":overlap"}, overlap_seen, 0);
    last_per  = xp;
    last_high = xh;
  endtask

  initial begin
    int S;
    bit bad_idle;
    //            off  hi   lo   extra kind per  high lat
    tbl[0] = '{   3,   5,   5, 1'b0, 1,  10,   5,   15};
    tbl[1] = '{  10,  25,  25, 1'b1, 1,  50,  25,   62};
    tbl[2] = '{  10,  25,  25, 1'b0, 1,  50,  25,   62};
    tbl[3] = '{   0,   0,   1, 1'b0, 2,  50,  25, 1000};
    tbl[4] = '{ 498, 250, 250, 1'b0, 1, 500, 250, 1000};
    tbl[5] = '{ 499, 250, 250, 1'b0, 2, 500, 250, 1000};
    tbl[6] = '{  -3,  20,  10, 1'b0, 1,  30,  20,   59};
    tbl[7] = '{   0,   1,   1, 1'b0, 1,   2,   1,    4};
    tbl[8] = '{   5,   9,   1, 1'b1, 1,  10,   9,   17};

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    check("reset:busy", busy, 0);
    check("reset:valid", valid, 0);
    check("reset:timeout", timeout, 0);
    check("reset:period_count", period_count, 0);
    check("reset:high_count", high_count, 0);
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++)
      run_case($sformatf("vec%0d", i), 1'b0, tbl[i].off, tbl[i].hi, tbl[i].lo, tbl[i].extra,
               1'b1, tbl[i].kind, tbl[i].per, tbl[i].high, tbl[i].lat);

    // Reset in the middle of a measurement
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    S = edge_n + 1;
    for (int i = 0; i < 20; i++) step(edge_n + 1 == S, wave(1'b0, edge_n + 1, S, 0, 30, 30), 1'b0);
    check("midrst:busy_before", busy, 1);
    step(1'b0, 1'b0, 1'b1);
    check("midrst:busy", busy, 0);
    check("midrst:valid", valid, 0);
    check("midrst:timeout", timeout, 0);
    check("midrst:period_count", period_count, 0);
    check("midrst:high_count", high_count, 0);
    bad_idle = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0) bad_idle = 1'b1;
    end
    check("midrst:quiet_after", bad_idle, 0);
    last_per  = 0;
    last_high = 0;

    // Randomized waveforms against the reference model
    for (int r = 0; r < 15; r++) begin
      rw_max = int'($urandom_range(300, 1));
      run_case($sformatf("rnd%0d", r), 1'b1, 0, 0, 1, 1'(($urandom_range(1, 0))),
               1'b0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
